// File: rtl/keypad_pkg.sv
// Shared FSM encoding, key codes and helper functions for the keypad entry scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPressed,
    StRelease
  } state_t;

  localparam logic [3:0]  KEY_CLEAR = 4'hA;
  localparam logic [3:0]  KEY_BACK  = 4'hB;
  localparam logic [3:0]  KEY_ENTER = 4'hF;
  localparam logic [12:0] MAX_ENTRY = 13'd8191;

  // Key code at [row][col] of the 4x4 matrix.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    unique case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

  // Index of the lowest line driven low; used for both rows and the one-hot-low column.
  function automatic logic [1:0] low_index(input logic [3:0] lines);
    if (!lines[0]) return 2'd0;
    if (!lines[1]) return 2'd1;
    if (!lines[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [13:0] bcd_to_bin(input logic [15:0] d);
    return 14'(d[15:12]) * 14'd1000 + 14'(d[11:8]) * 14'd100 +
           14'(d[7:4]) * 14'd10 + 14'(d[3:0]);
  endfunction

endpackage

// File: rtl/keypad_debounce_counter.sv
// Stable-cycle counter: counts enabled cycles up to LIMIT-1 and holds there until cleared.
module keypad_debounce_counter #(
  parameter int unsigned     WIDTH = 20,
  parameter logic [WIDTH-1:0] LIMIT = WIDTH'(500000)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [WIDTH-1:0] cnt_q;

  assign done = (cnt_q == LIMIT - WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !done) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/keypad_entry_scanner.sv
// 4x4 keypad scanner with debounce and 4-digit decimal entry delivered as a 13-bit value.
// Define KEYPAD_AUTOREPEAT_EN to re-emit a held digit key every REPEAT_CYCLES.
module keypad_entry_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_BITS       = 18,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [25:0] REPEAT_CYCLES   = 26'd25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  Row,
  output logic [3:0]  Col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [12:0] entry,
  output logic [12:0] num,
  output logic        num_valid,
  output logic        err
);

  if (SCAN_BITS == 0 || DEBOUNCE_CYCLES == '0 || REPEAT_CYCLES == '0) begin : g_param_check
    $error("keypad_entry_scanner: SCAN_BITS, DEBOUNCE_CYCLES and REPEAT_CYCLES must be nonzero");
  end

  state_t               state_q;
  logic [3:0]           row_meta_q, row_sync_q, cap_q, col_q;
  logic [SCAN_BITS-1:0] slot_q;
  logic [3:0]           key_code_q;
  logic                 key_valid_q, num_valid_q, err_q, enter_pend_q;
  logic [12:0]          entry_q, num_q;
  logic [15:0]          dig_q;

  logic        stable, all_high, dbc_en, dbc_done, rep_fire, apply;
  logic [3:0]  press_code;
  logic [16:0] cand;
  logic [15:0] dig_d;
  logic [12:0] entry_d;
  logic        err_d, enter_pend_d;

  assign stable     = (row_sync_q == cap_q);
  assign all_high   = (row_sync_q == 4'hF);
  assign press_code = key_map(low_index(cap_q), low_index(col_q));
  assign apply      = (state_q == StPressed) || rep_fire;

  // One counter serves both the press debounce and the release debounce.
  assign dbc_en = ((state_q == StDebounce) && stable) || ((state_q == StRelease) && all_high);

  keypad_debounce_counter #(
    .WIDTH (20),
    .LIMIT (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!dbc_en),
    .en    (dbc_en),
    .done  (dbc_done)
  );

`ifdef KEYPAD_AUTOREPEAT_EN
  logic rep_en, rep_done;

  // Only digit keys repeat, and only while the same row pattern stays held.
  assign rep_en   = (state_q == StRelease) && stable && (key_code_q <= 4'd9);
  assign rep_fire = rep_en && rep_done;

  keypad_debounce_counter #(
    .WIDTH (26),
    .LIMIT (REPEAT_CYCLES)
  ) u_repeat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!rep_en || rep_done),
    .en    (rep_en),
    .done  (rep_done)
  );
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    dig_d        = dig_q;
    err_d        = err_q;
    enter_pend_d = 1'b0;
    cand         = 17'(entry_q) * 17'd10 + 17'(press_code);
    if (enter_pend_q) begin
      dig_d = '0;
      err_d = 1'b0;
    end else if (apply) begin
      if (press_code <= 4'd9) begin
        if ((dig_q[15:12] == 4'd0) && (cand <= 17'(MAX_ENTRY))) begin
          dig_d = {dig_q[11:0], press_code};
        end else begin
          err_d = 1'b1;
        end
      end else begin
        case (press_code)
          KEY_CLEAR: begin
            dig_d = '0;
            err_d = 1'b0;
          end
          KEY_BACK:  dig_d = {4'd0, dig_q[15:4]};
          KEY_ENTER: enter_pend_d = 1'b1;
          default:   ;
        endcase
      end
    end
    entry_d = 13'(bcd_to_bin(dig_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q   <= 4'hF;
      row_sync_q   <= 4'hF;
      state_q      <= StScan;
      col_q        <= 4'b1110;
      slot_q       <= '0;
      cap_q        <= 4'hF;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      num_q        <= '0;
      num_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      dig_q        <= '0;
      entry_q      <= '0;
      enter_pend_q <= 1'b0;
    end else begin
      row_meta_q   <= Row;
      row_sync_q   <= row_meta_q;
      key_valid_q  <= 1'b0;
      num_valid_q  <= 1'b0;
      dig_q        <= dig_d;
      entry_q      <= entry_d;
      err_q        <= err_d;
      enter_pend_q <= enter_pend_d;

      if (apply) begin
        key_code_q  <= press_code;
        key_valid_q <= 1'b1;
        if (press_code == KEY_ENTER) begin
          num_q       <= entry_q;
          num_valid_q <= 1'b1;
        end
      end

      unique case (state_q)
        StScan: begin
          slot_q <= slot_q + SCAN_BITS'(1);
          if (&slot_q) begin
            if (!all_high) begin
              state_q <= StDebounce;
              cap_q   <= row_sync_q;
            end else begin
              col_q <= {col_q[2:0], col_q[3]};
            end
          end
        end
        StDebounce: begin
          if (!stable) begin
            state_q <= StScan;
            slot_q  <= '0;
          end else if (dbc_done) begin
            state_q <= StPressed;
          end
        end
        StPressed: state_q <= StRelease;
        StRelease: begin
          if (all_high && dbc_done) begin
            state_q <= StScan;
            slot_q  <= '0;
          end
        end
      endcase
    end
  end

  assign Col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign entry     = entry_q;
  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Bench for keypad_entry_scanner: models the key matrix and checks entry behaviour.
module tb_keypad_entry_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  Row, Col, key_code;
  logic        key_valid, num_valid, err;
  logic [12:0] entry, num;

  logic [15:0] held;
  logic        ovr_en;
  logic [3:0]  ovr, model_rows;

  int total = 0;
  int bad   = 0;
  int kv_count = 0;

  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_entry_scanner #(
    .SCAN_BITS       (2),
    .DEBOUNCE_CYCLES (20'd4),
    .REPEAT_CYCLES   (26'd16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Row       (Row),
    .Col       (Col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .entry     (entry),
    .num       (num),
    .num_valid (num_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Matrix model: a held key pulls its row low while its column is driven low.
  always_comb begin
    model_rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !Col[c]) model_rows[r] = 1'b0;
  end
  assign Row = ovr_en ? ovr : model_rows;

  typedef struct {
    logic [3:0]  key;
    int          ent;
    int          err_nx;
    int          nv;
    int          nm;
    int          ent_nx;
  } vec_t;
  vec_t vecs [$];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (key_valid === 1'b1) kv_count++;
  endtask

  function automatic logic [15:0] mask_of(input logic [3:0] code);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) if (KMAP[i] == code) m[i] = 1'b1;
    return m;
  endfunction

  task automatic press(input logic [15:0] mask, output int ok, output int kc, output int ent_kv,
                       output int nv, output int nm, output int ent_nx, output int err_nx,
                       output int kvs);
    int kv0;
    kv0 = kv_count;
    ok = 0; kc = 0; ent_kv = 0; nv = 0; nm = 0;
    held = mask;
    for (int i = 0; i < 200 && ok == 0; i++) begin
      tick();
      if (key_valid === 1'b1) begin
        ok = 1; kc = int'(key_code); ent_kv = int'(entry); nv = int'(num_valid); nm = int'(num);
      end
    end
    tick();
    ent_nx = int'(entry);
    err_nx = int'(err);
    held = '0;
    repeat (20) tick();
    kvs = kv_count - kv0;
  endtask

  task automatic press_check(input string tag, input logic [3:0] key, input int e_ent,
                             input int e_err, input int e_nv, input int e_nm, input int e_nx);
    int ok, kc, ent_kv, nv, nm, ent_nx, err_nx, kvs;
    press(mask_of(key), ok, kc, ent_kv, nv, nm, ent_nx, err_nx, kvs);
    check({tag, " accepted"}, ok, 1);
    check({tag, " key_code"}, kc, int'(key));
    check({tag, " entry"}, ent_kv, e_ent);
    check({tag, " num_valid"}, nv, e_nv);
    if (e_nv != 0) check({tag, " num"}, nm, e_nm);
    check({tag, " entry_next"}, ent_nx, e_nx);
    check({tag, " err"}, err_nx, e_err);
    check({tag, " pulses"}, kvs, 1);
  endtask

  initial begin
    int ok, kc, ent_kv, nv, nm, ent_nx, err_nx, kvs, kv0, col_ok, found, ci;
    int rv, re, e_ent, e_nv, e_nm, e_nx;
    logic [3:0] k, prev;

    held = '0; ovr_en = 1'b0; ovr = 4'hF; rst_n = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst Col", int'(Col), 4'b1110);
    check("rst key_code", int'(key_code), 0);
    check("rst key_valid", int'(key_valid), 0);
    check("rst entry", int'(entry), 0);
    check("rst num", int'(num), 0);
    check("rst num_valid", int'(num_valid), 0);
    check("rst err", int'(err), 0);
    rst_n = 1'b1;
    tick();
    check("post-rst Col", int'(Col), 4'b1110);

    // Press "5": column 1 must stay driven until release is debounced
    kv0 = kv_count; ok = 0;
    held = mask_of(4'h5);
    for (int i = 0; i < 200 && ok == 0; i++) begin
      tick();
      if (key_valid === 1'b1) begin ok = 1; kc = int'(key_code); ent_kv = int'(entry); end
    end
    check("five accepted", ok, 1);
    check("five key_code", kc, 5);
    check("five entry", ent_kv, 5);
    col_ok = 1;
    repeat (8) begin tick(); if (Col !== 4'b1101) col_ok = 0; end
    held = '0;
    repeat (3) begin tick(); if (Col !== 4'b1101) col_ok = 0; end
    check("five Col held", col_ok, 1);
    repeat (20) tick();
    check("five pulses", kv_count - kv0, 1);

    // Table of key sequences with hand-derived expectations
    vecs.push_back('{4'hA, 0, 0, 0, 0, 0});
    vecs.push_back('{4'h8, 8, 0, 0, 0, 8});
    vecs.push_back('{4'h1, 81, 0, 0, 0, 81});
    vecs.push_back('{4'h9, 819, 0, 0, 0, 819});
    vecs.push_back('{4'h1, 8191, 0, 0, 0, 8191});
    vecs.push_back('{4'h2, 8191, 1, 0, 0, 8191});
    vecs.push_back('{4'hA, 0, 0, 0, 0, 0});
    vecs.push_back('{4'h1, 1, 0, 0, 0, 1});
    vecs.push_back('{4'h2, 12, 0, 0, 0, 12});
    vecs.push_back('{4'h3, 123, 0, 0, 0, 123});
    vecs.push_back('{4'hB, 12, 0, 0, 0, 12});
    vecs.push_back('{4'hF, 12, 0, 1, 12, 0});
    vecs.push_back('{4'hE, 0, 0, 0, 0, 0});
    vecs.push_back('{4'h0, 0, 0, 0, 0, 0});
    vecs.push_back('{4'h7, 7, 0, 0, 0, 7});
    vecs.push_back('{4'hC, 7, 0, 0, 0, 7});
    vecs.push_back('{4'hD, 7, 0, 0, 0, 7});
    vecs.push_back('{4'hF, 7, 0, 1, 7, 0});
    for (int i = 0; i < vecs.size(); i++)
      press_check($sformatf("vec%0d", i), vecs[i].key, vecs[i].ent, vecs[i].err_nx,
                  vecs[i].nv, vecs[i].nm, vecs[i].ent_nx);

    // Bounce: short low pulses never qualify, a steady low does once
    kv0 = kv_count;
    ovr_en = 1'b1;
    repeat (3) begin
      ovr = 4'b1110; repeat (2) tick();
      ovr = 4'b1111; repeat (2) tick();
    end
    repeat (20) tick();
    check("bounce pulses", kv_count - kv0, 0);
    kv0 = kv_count;
    ovr = 4'b1110; repeat (20) tick();
    ovr = 4'b1111; repeat (20) tick();
    check("steady pulses", kv_count - kv0, 1);
    ovr_en = 1'b0;

    // Simultaneous rows 1 and 3 in column 1: lowest row wins
    press(mask_of(4'h5) | mask_of(4'h0), ok, kc, ent_kv, nv, nm, ent_nx, err_nx, kvs);
    check("simul accepted", ok, 1);
    check("simul key_code", kc, 5);
    check("simul pulses", kvs, 1);

    // Randomized keys against an arithmetic model of the entry value
    rv = 0; re = 0;
    for (int i = 0; i < 40; i++) begin
      k = (i == 0) ? 4'hA : 4'($urandom_range(0, 15));
      e_nv = 0; e_nm = 0;
      if (k <= 4'd9) begin
        if (rv < 1000 && rv * 10 + int'(k) <= 8191) rv = rv * 10 + int'(k);
        else re = 1;
        e_ent = rv; e_nx = rv;
      end else if (k == 4'hA) begin
        rv = 0; re = 0; e_ent = 0; e_nx = 0;
      end else if (k == 4'hB) begin
        rv = rv / 10; e_ent = rv; e_nx = rv;
      end else if (k == 4'hF) begin
        e_nv = 1; e_nm = rv; e_ent = rv; rv = 0; re = 0; e_nx = 0;
      end else begin
        e_ent = rv; e_nx = rv;
      end
      press_check($sformatf("rnd%0d", i), k, e_ent, re, e_nv, e_nm, e_nx);
    end

    // Reset asserted mid-debounce
    press_check("pre-rst A", 4'hA, 0, 0, 0, 0, 0);
    press_check("pre-rst 3", 4'h3, 3, 0, 0, 0, 3);
    prev = Col; found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      if (Col !== prev) found = 1;
    end
    check("col rotate seen", found, 1);
    ci = 0;
    for (int c = 0; c < 4; c++) if (!Col[c]) ci = c;
    kv0 = kv_count;
    held = 16'd1 << ci;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("mid-rst key_valid", int'(key_valid), 0);
    check("mid-rst Col", int'(Col), 4'b1110);
    check("mid-rst key_code", int'(key_code), 0);
    check("mid-rst entry", int'(entry), 0);
    check("mid-rst num", int'(num), 0);
    check("mid-rst err", int'(err), 0);
    held = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("mid-rst pulses", kv_count - kv0, 0);

    // Long hold of a digit, then of a non-digit
    kv0 = kv_count; ok = 0;
    held = mask_of(4'h7);
    for (int i = 0; i < 200 && ok == 0; i++) begin tick(); if (key_valid === 1'b1) ok = 1; end
    check("hold7 accepted", ok, 1);
    repeat (50) tick();
    held = '0;
    repeat (20) tick();
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold7 pulses", kv_count - kv0, 4);
    check("hold7 entry", int'(entry), 7777);
`else
    check("hold7 pulses", kv_count - kv0, 1);
    check("hold7 entry", int'(entry), 7);
`endif
    kv0 = kv_count; ok = 0;
    held = mask_of(4'hA);
    for (int i = 0; i < 200 && ok == 0; i++) begin tick(); if (key_valid === 1'b1) ok = 1; end
    check("holdA accepted", ok, 1);
    repeat (50) tick();
    held = '0;
    repeat (20) tick();
    check("holdA pulses", kv_count - kv0, 1);
    check("holdA entry", int'(entry), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
